cmd_decoder: RTL

Parametrised command-frame decoder for the logic-analyzer control path. It watches the host byte stream (byte plus a `ready` strobe), finds a sync byte and decodes a command byte carrying an opcode and a channel index. It collects a fixed number of argument bytes and then sets, clears or toggles one bit of a multi-bit `switch` vector, or loads an argument register. It supersedes single-byte, single-output match-and-toggle decoding and adds frame timeout and error reporting.

---
 rtl/cmd_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cmd_decoder.sv
// Host command-frame decoder: SYNC, cmd(op,idx), ARG_BYTES args -> set/clear/toggle switch[idx] or load arg.
// Optional checksum byte after the args when CMD_CHECKSUM_EN is defined. Data input is rx_byte ("byte" is reserved in SV).
module cmd_decoder #(
  parameter int                DATA_W    = 8,
  parameter int                N_CMD     = 4,
  parameter int                ARG_BYTES = 2,
  parameter logic [DATA_W-1:0] SYNC      = 8'hAB,
  parameter int                TIMEOUT   = 1023
) (
  input  logic                          rdclk,
  input  logic                          nreset,
  input  logic                          en,
  input  logic [DATA_W-1:0]             rx_byte,
  input  logic                          ready,
  output logic [N_CMD-1:0]              switch,
  output logic [ARG_BYTES*DATA_W-1:0]   arg,
  output logic [N_CMD-1:0]              cmd_strobe,
  output logic                          err,
  output logic                          busy
);
  localparam int IDX_W = DATA_W - 2;
  localparam int AW    = ARG_BYTES * DATA_W;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int CW    = $clog2(ARG_BYTES + 1);
  localparam logic [DATA_W-1:0] N_LIM = DATA_W'(N_CMD);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_CHK, S_EXEC} state_t;

  state_t           state;
  logic [1:0]       rdy_sr;
  logic [1:0]       op_r;
  logic [IDX_W-1:0] idx_r;
  logic [AW-1:0]    shadow;
  logic [CW-1:0]    acnt;
  logic [TW-1:0]    tcnt;
  logic [N_CMD-1:0] sel, sw_nxt;
  logic             acc, idx_ok, tout;
`ifdef CMD_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // rdy_sr[0] is the newest sample; a byte is taken on a 0->1 transition
  assign acc    = en & rdy_sr[0] & ~rdy_sr[1];
  assign idx_ok = {2'b00, rx_byte[IDX_W-1:0]} < N_LIM;
  assign tout   = (tcnt == TW'(TIMEOUT));

  for (genvar i = 0; i < N_CMD; i++) begin : g_sel
    assign sel[i] = (idx_r == IDX_W'(i));
  end

  always_comb begin
    sw_nxt = switch;
    case (op_r)
      2'b00:   sw_nxt = switch ^ sel;
      2'b01:   sw_nxt = switch | sel;
      2'b10:   sw_nxt = switch & ~sel;
      default: sw_nxt = switch;
    endcase
  end

  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      state      <= S_IDLE;
      rdy_sr     <= '0;
      op_r       <= '0;
      idx_r      <= '0;
      shadow     <= '0;
      acnt       <= '0;
      tcnt       <= '0;
      switch     <= '0;
      arg        <= '0;
      cmd_strobe <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      // pulses always fall back, even while en is low
      cmd_strobe <= '0;
      err        <= 1'b0;
      if (en) begin
        rdy_sr <= {rdy_sr[0], ready};
        if (acc || state == S_IDLE) tcnt <= '0;
        else if (!tout)             tcnt <= tcnt + TW'(1);

        case (state)
          S_IDLE: begin
            if (acc && rx_byte == SYNC) begin
              state <= S_CMD;
              busy  <= 1'b1;
            end
          end
          S_CMD: begin
            if (acc) begin
              if (idx_ok) begin
                op_r  <= rx_byte[DATA_W-1 -: 2];
                idx_r <= rx_byte[IDX_W-1:0];
                acnt  <= '0;
                state <= S_ARG;
`ifdef CMD_CHECKSUM_EN
                csum  <= rx_byte;
`endif
              end else begin
                err   <= 1'b1;
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else if (tout) begin
              err   <= 1'b1;
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_ARG: begin
            if (acc) begin
              shadow <= (shadow << DATA_W) | AW'(rx_byte);
              acnt   <= acnt + CW'(1);
`ifdef CMD_CHECKSUM_EN
              csum   <= csum ^ rx_byte;
              if (acnt == CW'(ARG_BYTES - 1)) state <= S_CHK;
`else
              if (acnt == CW'(ARG_BYTES - 1)) state <= S_EXEC;
`endif
            end else if (tout) begin
              err    <= 1'b1;
              shadow <= '0;
              state  <= S_IDLE;
              busy   <= 1'b0;
            end
          end
`ifdef CMD_CHECKSUM_EN
          S_CHK: begin
            if (acc) begin
              if (rx_byte == csum) begin
                state <= S_EXEC;
              end else begin
                err    <= 1'b1;
                shadow <= '0;
                state  <= S_IDLE;
                busy   <= 1'b0;
              end
            end else if (tout) begin
              err    <= 1'b1;
              shadow <= '0;
              state  <= S_IDLE;
              busy   <= 1'b0;
            end
          end
`endif
          S_EXEC: begin
            arg        <= shadow;
            switch     <= sw_nxt;
            cmd_strobe <= sel;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
